// File: rtl/cjb_alu_op_sequencer_pkg.sv
// Shared definitions for the ALU op sequencer: FSM states, CNVZ bit positions and
// Func_Sel unit-group codes.
package cjb_alu_op_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_RESP = 2'b10
   } seq_state_t;

   localparam int CNVZ_C = 3;
   localparam int CNVZ_N = 2;
   localparam int CNVZ_V = 1;
   localparam int CNVZ_Z = 0;

   localparam logic [1:0] GRP_ARITH = 2'b00;
   localparam logic [1:0] GRP_LOGIC = 2'b01;
   localparam logic [1:0] GRP_SHIFT = 2'b10;
   localparam logic [1:0] GRP_CONST = 2'b11;

endpackage

// File: rtl/cjb_cnvz_status_reg.sv
// Architectural CNVZ flag register; a synchronous clear takes priority over a write.
module cjb_cnvz_status_reg
   import cjb_alu_op_sequencer_pkg::*;
#(
   parameter logic [3:0] RST_VAL = 4'b0000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       we,
   input  logic [3:0] d,
   output logic [3:0] q
);

   logic [3:0] status_d, status_q;

   always_comb begin
      status_d = status_q;
      if (clr) begin
         status_d = RST_VAL;
      end else if (we) begin
         status_d = d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         status_q <= RST_VAL;
      end else begin
         status_q <= status_d;
      end
   end

   assign q = status_q;

endmodule

// File: rtl/cjb_alu_op_sequencer.sv
// Initiator-side controller for the 8-bit ALU: accepts op requests, runs one or more
// chained ALU passes, keeps the CNVZ status register and returns the final result.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | Req_Ready high; waiting for a request
// ST_EXEC | ALU inputs driven from registers; one pass per cycle
// ST_RESP | Rsp_Valid high; response held until Rsp_Ready
module cjb_alu_op_sequencer
   import cjb_alu_op_sequencer_pkg::*;
#(
   parameter int         CNT_W      = 3,
   parameter logic [3:0] STATUS_RST = 4'b0000
) (
   input  logic             Clock,
   input  logic             Resetn,
   input  logic             Req_Valid,
   output logic             Req_Ready,
   input  logic [3:0]       Req_Func,
   input  logic [7:0]       Req_X,
   input  logic [7:0]       Req_Y,
   input  logic [1:0]       Req_K,
   input  logic [CNT_W-1:0] Req_Count,
   input  logic             Req_Use_C,
   input  logic             Req_Flag_WE,
   input  logic             Flag_Clr,
   output logic [3:0]       Func_Sel,
   output logic [7:0]       Operand_X,
   output logic [7:0]       Operand_Y,
   output logic [1:0]       Const_K,
   output logic             cin,
   input  logic [7:0]       ALU_Result,
   input  logic [3:0]       ALU_CNVZ,
   output logic             Rsp_Valid,
   input  logic             Rsp_Ready,
   output logic [7:0]       Rsp_Result,
   output logic [3:0]       Rsp_CNVZ,
   output logic [3:0]       Status_CNVZ
);

   seq_state_t       state_d, state_q;
   logic [3:0]       func_d, func_q;
   logic [7:0]       x_d, x_q;
   logic [7:0]       y_d, y_q;
   logic [1:0]       k_d, k_q;
   logic             cin_d, cin_q;
   logic             use_c_d, use_c_q;
   logic             flag_we_d, flag_we_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic [7:0]       rsp_result_d, rsp_result_q;
   logic [3:0]       rsp_cnvz_d, rsp_cnvz_q;
   logic             status_we;

   always_comb begin
      state_d      = state_q;
      func_d       = func_q;
      x_d          = x_q;
      y_d          = y_q;
      k_d          = k_q;
      cin_d        = cin_q;
      use_c_d      = use_c_q;
      flag_we_d    = flag_we_q;
      cnt_d        = cnt_q;
      rsp_result_d = rsp_result_q;
      rsp_cnvz_d   = rsp_cnvz_q;
      status_we    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (Req_Valid) begin
               func_d    = Req_Func;
               x_d       = Req_X;
               y_d       = Req_Y;
               k_d       = Req_K;
               cnt_d     = Req_Count;
               use_c_d   = Req_Use_C;
               flag_we_d = Req_Flag_WE;
               cin_d     = Req_Use_C ? Status_CNVZ[CNVZ_C] : 1'b0;
               state_d   = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (cnt_q != '0) begin
               // Chain result and carry into the next pass.
               x_d   = ALU_Result;
               cin_d = use_c_q ? ALU_CNVZ[CNVZ_C] : 1'b0;
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               rsp_result_d = ALU_Result;
               rsp_cnvz_d   = ALU_CNVZ;
               status_we    = flag_we_q;
               state_d      = ST_RESP;
            end
         end
         ST_RESP: begin
            if (Rsp_Ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q      <= ST_IDLE;
         func_q       <= '0;
         x_q          <= '0;
         y_q          <= '0;
         k_q          <= '0;
         cin_q        <= 1'b0;
         use_c_q      <= 1'b0;
         flag_we_q    <= 1'b0;
         cnt_q        <= '0;
         rsp_result_q <= '0;
         rsp_cnvz_q   <= '0;
      end else begin
         state_q      <= state_d;
         func_q       <= func_d;
         x_q          <= x_d;
         y_q          <= y_d;
         k_q          <= k_d;
         cin_q        <= cin_d;
         use_c_q      <= use_c_d;
         flag_we_q    <= flag_we_d;
         cnt_q        <= cnt_d;
         rsp_result_q <= rsp_result_d;
         rsp_cnvz_q   <= rsp_cnvz_d;
      end
   end

   cjb_cnvz_status_reg #(
      .RST_VAL (STATUS_RST)
   ) u_status (
      .clk   (Clock),
      .rst_n (Resetn),
      .clr   (Flag_Clr),
      .we    (status_we),
      .d     (ALU_CNVZ),
      .q     (Status_CNVZ)
   );

   assign Req_Ready  = (state_q == ST_IDLE);
   assign Rsp_Valid  = (state_q == ST_RESP);
   assign Func_Sel   = func_q;
   assign Operand_X  = x_q;
   assign Operand_Y  = y_q;
   assign Const_K    = k_q;
   assign cin        = cin_q;
   assign Rsp_Result = rsp_result_q;
   assign Rsp_CNVZ   = rsp_cnvz_q;

endmodule

// File: tb/tb_cjb_alu_op_sequencer.sv
// Bench for cjb_alu_op_sequencer: behavioural ALU on the ALU-side ports, op-level
// reference model for results/flags/status, directed corner cases plus random ops.
module tb_cjb_alu_op_sequencer;

   localparam int         CNT_W      = 3;
   localparam logic [3:0] STATUS_RST = 4'b0000;

   logic             Clock = 1'b0;
   logic             Resetn;
   logic             Req_Valid;
   logic             Req_Ready;
   logic [3:0]       Req_Func;
   logic [7:0]       Req_X;
   logic [7:0]       Req_Y;
   logic [1:0]       Req_K;
   logic [CNT_W-1:0] Req_Count;
   logic             Req_Use_C;
   logic             Req_Flag_WE;
   logic             Flag_Clr;
   logic [3:0]       Func_Sel;
   logic [7:0]       Operand_X;
   logic [7:0]       Operand_Y;
   logic [1:0]       Const_K;
   logic             cin;
   logic [7:0]       ALU_Result;
   logic [3:0]       ALU_CNVZ;
   logic             Rsp_Valid;
   logic             Rsp_Ready;
   logic [7:0]       Rsp_Result;
   logic [3:0]       Rsp_CNVZ;
   logic [3:0]       Status_CNVZ;

   int n_cmp = 0;
   int n_err = 0;
   logic [3:0]  mdl_status;
   logic [7:0]  exp_res;
   logic [3:0]  exp_cnvz;
   logic [11:0] alu_o;

   always #5 Clock = ~Clock;

   cjb_alu_op_sequencer #(
      .CNT_W      (CNT_W),
      .STATUS_RST (STATUS_RST)
   ) dut (
      .Clock       (Clock),
      .Resetn      (Resetn),
      .Req_Valid   (Req_Valid),
      .Req_Ready   (Req_Ready),
      .Req_Func    (Req_Func),
      .Req_X       (Req_X),
      .Req_Y       (Req_Y),
      .Req_K       (Req_K),
      .Req_Count   (Req_Count),
      .Req_Use_C   (Req_Use_C),
      .Req_Flag_WE (Req_Flag_WE),
      .Flag_Clr    (Flag_Clr),
      .Func_Sel    (Func_Sel),
      .Operand_X   (Operand_X),
      .Operand_Y   (Operand_Y),
      .Const_K     (Const_K),
      .cin         (cin),
      .ALU_Result  (ALU_Result),
      .ALU_CNVZ    (ALU_CNVZ),
      .Rsp_Valid   (Rsp_Valid),
      .Rsp_Ready   (Rsp_Ready),
      .Rsp_Result  (Rsp_Result),
      .Rsp_CNVZ    (Rsp_CNVZ),
      .Status_CNVZ (Status_CNVZ)
   );

   // Behavioural ALU: returns {C,N,V,Z,result}.
   function automatic logic [11:0] alu_f(input logic [3:0] f, input logic [7:0] x,
                                         input logic [7:0] y, input logic [1:0] k,
                                         input logic ci);
      logic [8:0] s;
      logic [7:0] r, b;
      logic       c, v, cc;
      c = 1'b0; v = 1'b0; r = 8'h00; b = y; s = 9'h000; cc = ci;
      case (f[3:2])
         2'b00: begin
            case (f[1:0])
               2'b00: b = y;
               2'b01: b = ~y;
               2'b10: begin b = 8'h00; cc = 1'b1; end
               default: b = 8'hFF;
            endcase
            s = {1'b0, x} + {1'b0, b} + {8'h00, cc};
            r = s[7:0];
            c = s[8];
            v = (x[7] == b[7]) && (r[7] != x[7]);
         end
         2'b01: begin
            case (f[1:0])
               2'b00: r = x & y;
               2'b01: r = x | y;
               2'b10: r = x ^ y;
               default: r = ~x;
            endcase
         end
         2'b10: begin
            case (f[1:0])
               2'b00: begin r = {x[6:0], ci}; c = x[7]; end
               2'b01: begin r = {ci, x[7:1]}; c = x[0]; end
               2'b10: begin r = {x[6:0], x[7]}; c = x[7]; end
               default: begin r = {x[0], x[7:1]}; c = x[0]; end
            endcase
         end
         default: r = x + {6'b000000, k} + {7'h00, f[0]};
      endcase
      return {c, r[7], v, (r == 8'h00), r};
   endfunction

   assign alu_o      = alu_f(Func_Sel, Operand_X, Operand_Y, Const_K, cin);
   assign ALU_Result = alu_o[7:0];
   assign ALU_CNVZ   = alu_o[11:8];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   // Op-level reference: Count+1 passes with X and carry chained; updates model status.
   task automatic model_op(input logic [3:0] f, input logic [7:0] x, input logic [7:0] y,
                           input logic [1:0] k, input int cnt, input logic use_c,
                           input logic we, input logic clr);
      logic [7:0]  xx;
      logic        c;
      logic [11:0] o;
      xx = x;
      c  = use_c ? mdl_status[3] : 1'b0;
      o  = '0;
      for (int i = 0; i <= cnt; i++) begin
         o  = alu_f(f, xx, y, k, c);
         xx = o[7:0];
         c  = use_c ? o[11] : 1'b0;
      end
      exp_res  = o[7:0];
      exp_cnvz = o[11:8];
      if (clr) mdl_status = STATUS_RST;
      else if (we) mdl_status = exp_cnvz;
   endtask

   task automatic run_op(input logic [3:0] f, input logic [7:0] x, input logic [7:0] y,
                         input logic [1:0] k, input int cnt, input logic use_c,
                         input logic we, input logic clr, input int bp);
      logic [3:0] st_before;
      st_before = mdl_status;
      model_op(f, x, y, k, cnt, use_c, we, clr);
      chk("req_ready_idle", Req_Ready, 1);
      Req_Valid = 1'b1; Req_Func = f; Req_X = x; Req_Y = y; Req_K = k;
      Req_Count = CNT_W'(cnt); Req_Use_C = use_c; Req_Flag_WE = we;
      step();
      Req_Valid = 1'b0;
      Req_X = 8'($urandom); Req_Func = 4'($urandom);
      chk("req_ready_exec", Req_Ready, 0);
      chk("alu_func", Func_Sel, f);
      chk("alu_y", Operand_Y, y);
      for (int i = 1; i <= cnt + 1; i++) begin
         if (i == cnt + 1) Flag_Clr = clr;
         if (i > 1) chk("rsp_valid_early", Rsp_Valid, 0);
         if (i <= cnt) chk("status_hold", Status_CNVZ, st_before);
         step();
      end
      Flag_Clr = 1'b0;
      chk("rsp_valid", Rsp_Valid, 1);
      chk("rsp_result", Rsp_Result, exp_res);
      chk("rsp_cnvz", Rsp_CNVZ, exp_cnvz);
      chk("status", Status_CNVZ, mdl_status);
      for (int i = 0; i < bp; i++) begin
         Req_Valid = 1'b1;
         Req_X = 8'($urandom); Req_Count = CNT_W'($urandom);
         step();
         chk("bp_valid", Rsp_Valid, 1);
         chk("bp_req_ready", Req_Ready, 0);
         chk("bp_result", {Rsp_CNVZ, Rsp_Result}, {exp_cnvz, exp_res});
         chk("bp_status", Status_CNVZ, mdl_status);
      end
      Req_Valid = 1'b0;
      Rsp_Ready = 1'b1;
      step();
      Rsp_Ready = 1'b0;
      chk("rsp_done", Rsp_Valid, 0);
      chk("req_ready_back", Req_Ready, 1);
   endtask

   task automatic check_reset_state();
      chk("rst_rsp_valid", Rsp_Valid, 0);
      chk("rst_req_ready", Req_Ready, 1);
      chk("rst_status", Status_CNVZ, STATUS_RST);
      chk("rst_alu_side", {Func_Sel, Operand_X, Operand_Y, Const_K, cin}, 0);
      chk("rst_rsp", {Rsp_Result, Rsp_CNVZ}, 0);
   endtask

   initial begin
      Resetn = 1'b0; Req_Valid = 1'b0; Req_Func = '0; Req_X = '0; Req_Y = '0;
      Req_K = '0; Req_Count = '0; Req_Use_C = 1'b0; Req_Flag_WE = 1'b0;
      Flag_Clr = 1'b0; Rsp_Ready = 1'b0;
      mdl_status = STATUS_RST;
      #3;
      check_reset_state();
      @(negedge Clock);
      Resetn = 1'b1;
      step();

      // Single pass with signed overflow.
      run_op(4'b0000, 8'h7F, 8'h01, 2'd0, 0, 1'b0, 1'b1, 1'b0, 0);
      chk("sp_result", Rsp_Result, 8'h80);
      // Set status C, then a 4-pass shift-left chained through carry.
      run_op(4'b0000, 8'hFF, 8'h01, 2'd0, 0, 1'b0, 1'b1, 1'b0, 0);
      chk("carry_set", Status_CNVZ[3], 1);
      run_op(4'b1000, 8'h81, 8'h00, 2'd0, 3, 1'b1, 1'b1, 1'b0, 0);
      chk("mp_result", Rsp_Result, 8'h1C);
      // Long backpressure with stray requests.
      run_op(4'b0110, 8'hA5, 8'h3C, 2'd1, 2, 1'b0, 1'b1, 1'b0, 10);
      // Clear on the same edge as a flag write.
      run_op(4'b0000, 8'hFF, 8'h01, 2'd0, 1, 1'b0, 1'b1, 1'b1, 0);
      chk("clr_status", Status_CNVZ, STATUS_RST);

      // Reset in the middle of a long op.
      Req_Valid = 1'b1; Req_Func = 4'b1010; Req_X = 8'h5A; Req_Count = CNT_W'(7);
      Req_Use_C = 1'b1; Req_Flag_WE = 1'b1;
      step();
      Req_Valid = 1'b0;
      step(); step(); step();
      Resetn = 1'b0;
      mdl_status = STATUS_RST;
      #2;
      check_reset_state();
      @(negedge Clock);
      Resetn = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("abort_no_rsp", Rsp_Valid, 0);
      end
      run_op(4'b0001, 8'h10, 8'h20, 2'd0, 0, 1'b1, 1'b1, 1'b0, 0);

      for (int n = 0; n < 40; n++) begin
         run_op(4'($urandom), 8'($urandom), 8'($urandom), 2'($urandom),
                int'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                ($urandom_range(0, 4) == 0), int'($urandom_range(0, 5)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
